// File: rtl/ddr3_refresh_ctl.sv
// DDR3 auto-refresh controller.
// Counts tREFI intervals, accumulates postponed refreshes, and when granted the command bus
// issues PREA followed by back-to-back REF commands until the postponed count is drained.
// Optional refresh pull-in (issue REFs early while the controller is idle) is built when the
// macro DDR3_REFRESH_PULLIN_EN is defined.
module ddr3_refresh_ctl #(
  parameter int unsigned DDR_FREQ_MHZ = 100,
  parameter int unsigned DDR_TREFI    = 7800,
  parameter int unsigned DDR_TRFC     = 110,
  parameter int unsigned DDR_TRP      = 15,
  parameter int unsigned DDR_RANKS    = 1,
  parameter int unsigned MAX_PENDING  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 idle_i,
  output logic                 ref_req_o,
  output logic                 ref_urg_o,
  input  logic                 ref_gnt_i,
  output logic                 busy_o,
  output logic                 ref_done_o,
  output logic [3:0]           pending_o,
  output logic                 err_o,
  output logic [DDR_RANKS-1:0] dfi_cs_n_o,
  output logic                 dfi_ras_n_o,
  output logic                 dfi_cas_n_o,
  output logic                 dfi_we_n_o,
  output logic                 dfi_a10_o
);

  localparam int unsigned TCK    = 1000 / DDR_FREQ_MHZ;
  localparam int unsigned CREFI  = DDR_TREFI / TCK - 1;
  localparam int unsigned CRP    = (DDR_TRP + TCK - 1) / TCK;
  localparam int unsigned CRFC   = (DDR_TRFC + TCK - 1) / TCK;
  localparam int unsigned CNT_W  = (CREFI < 2) ? 1 : $clog2(CREFI + 1);
  localparam int unsigned WAIT_W = 16;

  localparam logic [CNT_W-1:0]  CREFI_LD = CNT_W'(CREFI);
  // Wait loads are "cycles remaining minus one" so the wait state ends when the count hits 0
  localparam logic [WAIT_W-1:0] CRP_LD   = WAIT_W'((CRP >= 2) ? CRP - 2 : 0);
  localparam logic [WAIT_W-1:0] CRFC_LD  = WAIT_W'((CRFC >= 2) ? CRFC - 2 : 0);
  localparam logic [3:0]        MAX_P    = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    StIdle, StReq, StPrea, StWrp, StRefr, StWrfc, StDone
  } state_t;

  state_t              r_state, w_state_d, w_drain_st;
  logic [WAIT_W-1:0]   r_wait, w_wait_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_pending, w_pending_d;
  logic                r_err, w_err_set;
  logic                w_tick, w_ref, w_ref_pullin, w_tick_credit, w_ref_norm, w_tick_pend;
  logic                r_ref_req, r_busy, r_done;
  logic [DDR_RANKS-1:0] r_cs_n;
  logic                r_ras_n, r_cas_n, r_we_n, r_a10;
  logic                w_is_prea, w_is_refr;

  // Interval counter: reloads on tick and holds at CREFI while disabled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= CREFI_LD;
    end else if (!enable_i || w_tick) begin
      r_cnt <= CREFI_LD;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign w_tick = enable_i && (r_cnt == '0);
  assign w_ref  = (r_state == StRefr);

`ifdef DDR3_REFRESH_PULLIN_EN
  logic [3:0] r_credit;

  // A REF issued with nothing postponed is a pull-in; ticks repay outstanding credit first
  assign w_ref_pullin  = w_ref && (r_pending == '0);
  assign w_tick_credit = w_tick && (r_credit != '0);

  // Credit counter: +1 per pulled-in REF, -1 per tick absorbed
  always_ff @(posedge clock) begin
    if (reset) begin
      r_credit <= '0;
    end else if (w_ref_pullin && !w_tick_credit) begin
      r_credit <= r_credit + 4'd1;
    end else if (!w_ref_pullin && w_tick_credit) begin
      r_credit <= r_credit - 4'd1;
    end
  end
`else
  logic w_unused_idle;

  assign w_ref_pullin  = 1'b0;
  assign w_tick_credit = 1'b0;
  assign w_unused_idle = idle_i;
`endif

  assign w_ref_norm  = w_ref && !w_ref_pullin;
  assign w_tick_pend = w_tick && !w_tick_credit;

  // Next postponed count; a tick and a REF in the same cycle cancel out
  always_comb begin
    w_pending_d = r_pending;
    w_err_set   = 1'b0;
    if (w_tick_pend && !w_ref_norm) begin
      if (r_pending == MAX_P) begin
        w_err_set = 1'b1;
      end else begin
        w_pending_d = r_pending + 4'd1;
      end
    end else if (!w_tick_pend && w_ref_norm) begin
      w_pending_d = r_pending - 4'd1;
    end
  end

  // Pending count and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_err     <= r_err | w_err_set;
    end
  end

  // Decisions use the updated count so a tick in the deciding cycle is honoured at once
  assign w_drain_st = (w_pending_d != '0) ? StRefr : StDone;

  // Sequencer next-state and wait-timer logic
  always_comb begin
    w_state_d = r_state;
    w_wait_d  = r_wait;
    case (r_state)
      StIdle: begin
        if (w_pending_d != '0) begin
          w_state_d = StReq;
        end
`ifdef DDR3_REFRESH_PULLIN_EN
        else if (idle_i && (r_credit < MAX_P)) begin
          w_state_d = StReq;
        end
`endif
      end
      StReq: begin
        if (ref_gnt_i) begin
          w_state_d = StPrea;
        end
      end
      StPrea: begin
        if (CRP <= 1) begin
          w_state_d = StRefr;
        end else begin
          w_state_d = StWrp;
          w_wait_d  = CRP_LD;
        end
      end
      StWrp: begin
        if (r_wait == '0) begin
          w_state_d = StRefr;
        end else begin
          w_wait_d = r_wait - WAIT_W'(1);
        end
      end
      StRefr: begin
        if (CRFC <= 1) begin
          w_state_d = w_drain_st;
        end else begin
          w_state_d = StWrfc;
          w_wait_d  = CRFC_LD;
        end
      end
      StWrfc: begin
        if (r_wait == '0) begin
          w_state_d = w_drain_st;
        end else begin
          w_wait_d = r_wait - WAIT_W'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_is_prea = (w_state_d == StPrea);
  assign w_is_refr = (w_state_d == StRefr);

  // FSM state register with outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_wait    <= '0;
      r_ref_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= '1;
      r_ras_n   <= 1'b1;
      r_cas_n   <= 1'b1;
      r_we_n    <= 1'b1;
      r_a10     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_wait    <= w_wait_d;
      r_ref_req <= (w_state_d == StReq);
      r_busy    <= (w_state_d != StIdle) && (w_state_d != StReq);
      r_done    <= (w_state_d == StDone);
      r_cs_n    <= (w_is_prea || w_is_refr) ? '0 : '1;
      r_ras_n   <= !(w_is_prea || w_is_refr);
      r_cas_n   <= !w_is_refr;
      r_we_n    <= !w_is_prea;
      r_a10     <= w_is_prea;
    end
  end

  assign ref_req_o   = r_ref_req;
  assign ref_urg_o   = (r_pending == MAX_P);
  assign busy_o      = r_busy;
  assign ref_done_o  = r_done;
  assign pending_o   = r_pending;
  assign err_o       = r_err;
  assign dfi_cs_n_o  = r_cs_n;
  assign dfi_ras_n_o = r_ras_n;
  assign dfi_cas_n_o = r_cas_n;
  assign dfi_we_n_o  = r_we_n;
  assign dfi_a10_o   = r_a10;

endmodule

// File: doc/ddr3_refresh_ctl.md
DDR3_REFRESH_CTL -- requirements
Module: ddr3_refresh_ctl

Interface
REQ-001 SHALL have parameter DDR_FREQ_MHZ, default 100: clock frequency; TCK = 1000/DDR_FREQ_MHZ ns, integer.
REQ-002 SHALL have parameter DDR_TREFI, default 7800: refresh interval, ns.
REQ-003 SHALL have parameter DDR_TRFC, default 110: REF-to-next-command time, ns.
REQ-004 SHALL have parameter DDR_TRP, default 15: PREA-to-REF time, ns.
REQ-005 SHALL have parameter DDR_RANKS, default 1, range 1..4: number of chip-selects driven.
REQ-006 SHALL have parameter MAX_PENDING, default 8, range 1..8: postponed-refresh limit.
REQ-007 SHALL use one clock and a synchronous, active-high reset, on ports `clock` and `reset`: `clock` in 1 is the rising-edge clock; `reset` in 1 is the synchronous active-high reset.
REQ-008 SHALL have ports:
- enable_i in 1: initialisation complete; interval counting enabled.
- idle_i in 1: controller has no queued work (pull-in hint).
- ref_req_o out 1: refresh wanted.
- ref_urg_o out 1: pending == MAX_PENDING.
- ref_gnt_i in 1: controller has closed traffic and grants the command bus.
- busy_o out 1: block owns the command bus.
- ref_done_o out 1: single-cycle pulse, sequence finished.
- pending_o out 4: postponed-refresh count.
- err_o out 1: sticky overflow flag.
- dfi_cs_n_o out DDR_RANKS; dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o out 1 each; dfi_a10_o out 1.

Function
REQ-009 Derived cycle counts SHALL be: CREFI = DDR_TREFI/TCK - 1; CRP = ceil(DDR_TRP/TCK); CRFC = ceil(DDR_TRFC/TCK).
REQ-010 Interval counter:
- While enable_i=1, decrements each cycle.
- At 0 it emits a one-cycle tick and reloads CREFI.
- While enable_i=0, holds at CREFI and emits no ticks.
REQ-011 Each tick SHALL increment pending.
- pending at MAX_PENDING with a tick: pending stays at MAX_PENDING and err_o sets.
- err_o is cleared only by reset.
REQ-012 Tick in the same cycle as a REF issue SHALL leave pending unchanged (+1-1).
REQ-013 States SHALL be IDLE, REQ, PREA, WRP, REFR, WRFC, DONE.
REQ-014 IDLE->REQ SHALL occur when pending>0; ref_req_o=1 exactly in REQ.
REQ-015 REQ->PREA SHALL occur on the cycle ref_gnt_i=1 is sampled; ref_gnt_i SHALL be ignored outside REQ.
REQ-016 PREA (one cycle) SHALL drive: all cs_n=0, ras_n=0, cas_n=1, we_n=0, a10=1; busy_o=1 from PREA through DONE.
REQ-017 WRP SHALL hold NOP so that REFR occurs exactly CRP cycles after PREA.
REQ-018 REFR (one cycle) SHALL:
- drive all cs_n=0, ras_n=0, cas_n=0, we_n=1;
- decrement pending.
REQ-019 WRFC SHALL hold NOP for CRFC-1 cycles, then:
- pending>0: go to REFR (back-to-back drain, no further PREA);
- otherwise: go to DONE.
REQ-020 DONE SHALL pulse ref_done_o for one cycle, then return to IDLE.
REQ-021 Outside PREA and REFR, command outputs SHALL be NOP: cs_n all 1, ras_n=cas_n=we_n=1, a10=0.
REQ-022 ref_urg_o SHALL equal (pending == MAX_PENDING) combinationally from the registered count.
REQ-023 enable_i falling mid-sequence SHALL NOT abort the sequence; only the counter freezes.

Reset
REQ-024 On reset, the block SHALL go to:
- state=IDLE, pending=0, counter=CREFI;
- err_o=0, ref_req_o=0, busy_o=0, ref_done_o=0;
- NOP outputs (cs_n all 1, ras_n=cas_n=we_n=1, a10=0).
REQ-025 Reset asserted mid-sequence SHALL take effect the next edge with no further REF issued.

Configuration
REQ-026 Macro DDR3_REFRESH_PULLIN_EN SHALL select refresh pull-in.
- Defined: a credit counter (0..MAX_PENDING) is added.
  - In IDLE with pending=0, idle_i=1 and credit<MAX_PENDING, the block enters REQ.
  - The resulting REF increments credit instead of decrementing pending.
  - While credit>0, a tick decrements credit instead of incrementing pending.
  - Credit clears on reset.
- Undefined: idle_i is ignored, no credit logic exists, and behaviour is exactly REQ-010..REQ-023.

Verification
REQ-027 Defaults, enable_i=1 from reset, ref_gnt_i=1 tied -> first ref_req_o at cycle 780, PREA at cycle 781, REF at cycle 783, ref_done_o at cycle 794.
REQ-028 ref_gnt_i held 0 for 8 ticks -> pending_o=8 and ref_urg_o=1; the 9th tick sets err_o=1 with pending_o still 8.
REQ-029 Grant with pending=3 -> one PREA, then 3 REFs spaced 11 cycles apart, pending_o=0, one ref_done_o pulse.
REQ-030 Tick coincident with a REF cycle, pending 2 -> pending_o stays 2 after that edge.
REQ-031 Reset asserted in WRFC -> next cycle IDLE, NOP, pending_o=0, busy_o=0, no further REF.
REQ-032 DDR3_REFRESH_PULLIN_EN defined, idle_i=1, pending=0, gnt=1 -> pulled-in REFs until credit=8; the next 8 ticks raise no ref_req_o; the 9th tick sets pending_o=1.
